k6502_run_ctl: RTL and testbench

//  Synthesizable run controller for k6502 test harnesses. Sequences the CPU reset
//  and counts bus cycles and opcode fetches. Detects the "JMP *" self-loop trap
//  and classifies it as pass or fail, with a cycle-budget watchdog.

---
 rtl/k6502_run_ctl.sv | 143 ++++++++++++++
 tb/tb_k6502_run_ctl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/k6502_run_ctl.sv
// Run controller for k6502 harnesses: CPU reset sequencing, cycle/fetch counters,
// JMP-* trap classification and watchdog. Optional fetch history: K6502_RUN_CTL_HIST_EN.
module k6502_run_ctl #(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 50,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRAP_REPEAT = 2,
  parameter logic [15:0] PASS_ADDR   = 16'hFFF0,
  parameter int unsigned HIST_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   a,
  input  logic                          sync,
  output logic                          cpu_rst_n,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              instr_cnt,
  output logic [15:0]                   trap_addr,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [15:0]                   hist_addr
);

  localparam int unsigned REP_W = $clog2(TRAP_REPEAT + 1);
  localparam int unsigned HW    = $clog2(HIST_DEPTH);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instr_q, instr_d;
  logic [REP_W-1:0]   rep_q, rep_d, rep_nxt;
  logic [15:0]        last_pc_q, last_pc_d;
  logic [15:0]        trap_q, trap_d;
  logic               pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic               trap_hit;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    rep_d     = rep_q;
    rep_nxt   = rep_q;
    last_pc_d = last_pc_q;
    trap_d    = trap_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;
    trap_hit  = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (hold_q == 8'(RST_CYCLES - 1)) state_d = S_RUN;
        else                              hold_d  = hold_q + 8'd1;
      end
      S_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        if (sync) begin
          if (instr_q != '1) instr_d = instr_q + CNT_W'(1);
          rep_nxt   = (a == last_pc_q) ? rep_q + REP_W'(1) : REP_W'(1);
          rep_d     = rep_nxt;
          last_pc_d = a;
          trap_hit  = (rep_nxt == REP_W'(TRAP_REPEAT));
        end
        // Trap is checked first so a same-cycle watchdog expiry never sets timeout.
        if (trap_hit) begin
          state_d = S_DONE;
          trap_d  = a;
          pass_d  = (a == PASS_ADDR);
          fail_d  = (a != PASS_ADDR);
        end else if (cycle_d >= CNT_W'(MAX_CYCLES - 1)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          fail_d  = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOLD;
      hold_q    <= '0;
      cycle_q   <= '0;
      instr_q   <= '0;
      rep_q     <= '0;
      last_pc_q <= '0;
      trap_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      rep_q     <= rep_d;
      last_pc_q <= last_pc_d;
      trap_q    <= trap_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
    end
  end

  assign cpu_rst_n = (state_q != S_HOLD);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = to_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
  assign trap_addr = trap_q;

`ifdef K6502_RUN_CTL_HIST_EN
  logic [15:0]   hist_mem [HIST_DEPTH];
  logic [HW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
      wr_ptr <= '0;
    end else if (state_q == S_RUN && sync) begin
      hist_mem[wr_ptr] <= a;
      wr_ptr           <= wr_ptr + HW'(1);
    end
  end

  // Unwritten slots are still zero from reset, so no valid tracking is needed.
  assign hist_addr = hist_mem[wr_ptr - HW'(1) - hist_idx];
`else
  logic unused_hist;
  assign unused_hist = ^hist_idx;
  assign hist_addr   = 16'h0000;
`endif

endmodule

// File: tb/tb_k6502_run_ctl.sv
// Self-checking bench for k6502_run_ctl: directed scenarios plus randomized runs
// against a fetch-queue reference model.
module tb_k6502_run_ctl;
  localparam int unsigned RST_CYCLES  = 2;
  localparam int unsigned MAX_CYCLES  = 50;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned TRAP_REPEAT = 2;
  localparam logic [15:0] PASS_ADDR   = 16'hFFF0;
  localparam int unsigned HIST_DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst, sync, cpu_rst_n, done, pass, fail, timeout;
  logic [15:0]       a, trap_addr, hist_addr;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
  logic [2:0]        hist_idx;

  k6502_run_ctl #(
    .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .TRAP_REPEAT(TRAP_REPEAT), .PASS_ADDR(PASS_ADDR), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .sync(sync), .cpu_rst_n(cpu_rst_n),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .trap_addr(trap_addr),
    .hist_idx(hist_idx), .hist_addr(hist_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edges since rst fell, run-cycle count, and the list of fetches.
  int          m_since = 0;
  int          m_cyc   = 0;
  int          m_instr = 0;
  bit          m_done = 0, m_pass = 0, m_fail = 0, m_to = 0;
  logic [15:0] m_trap = 0;
  logic [15:0] fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input logic [15:0] ad);
    bit trap;
    if (r) begin
      m_since = 0; m_cyc = 0; m_instr = 0;
      m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_trap = 0;
      fq.delete();
    end else begin
      if (m_since >= int'(RST_CYCLES) && !m_done) begin
        m_cyc++;
        trap = 0;
        if (s) begin
          m_instr++;
          fq.push_back(ad);
          if (fq.size() >= int'(TRAP_REPEAT)) begin
            trap = 1;
            for (int k = 1; k <= int'(TRAP_REPEAT); k++)
              if (fq[fq.size()-k] != ad) trap = 0;
          end
        end
        if (trap) begin
          m_done = 1; m_trap = ad;
          m_pass = (ad == PASS_ADDR); m_fail = (ad != PASS_ADDR);
        end else if (m_cyc == int'(MAX_CYCLES) - 1) begin
          m_done = 1; m_to = 1; m_fail = 1;
        end
      end
      if (m_since < 1000) m_since++;
    end
  endtask

  function automatic logic [15:0] hist_exp(input int idx);
`ifdef K6502_RUN_CTL_HIST_EN
    if (idx < fq.size()) return fq[fq.size()-1-idx];
    return 16'h0000;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_all();
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_since >= int'(RST_CYCLES)));
    chk("done",      32'(done),      32'(m_done));
    chk("pass",      32'(pass),      32'(m_pass));
    chk("fail",      32'(fail),      32'(m_fail));
    chk("timeout",   32'(timeout),   32'(m_to));
    chk("cycle_cnt", cycle_cnt,      32'(m_cyc));
    chk("instr_cnt", instr_cnt,      32'(m_instr));
    chk("trap_addr", 32'(trap_addr), 32'(m_trap));
    chk("hist_addr", 32'(hist_addr), 32'(hist_exp(int'(hist_idx))));
  endtask

  task automatic cyc(input bit r, input bit s, input logic [15:0] ad);
    @(negedge clk);
    rst = r; sync = s; a = ad;
    hist_idx = 3'($urandom_range(0, 7));
    @(posedge clk);
    model_edge(r, s, ad);
    #1 check_all();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < int'(RST_CYCLES); i++) cyc(1'b0, 1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] pool_addr();
    case ($urandom_range(0, 3))
      0: return 16'h8000;
      1: return 16'h8001;
      2: return PASS_ADDR;
      default: return 16'h9000;
    endcase
  endfunction

  initial begin
    rst = 1'b1; sync = 1'b0; a = '0; hist_idx = '0;

    // Reset sequence: cpu_rst_n low for exactly two clocks after rst falls.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000);
    chk("rst_cpu_low", 32'(cpu_rst_n), 32'd0);
    chk("rst_cycle0",  cycle_cnt,      32'd0);
    cyc(1'b0, 1'b1, 16'h1234);
    chk("hold_low1", 32'(cpu_rst_n), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("hold_high", 32'(cpu_rst_n), 32'd1);
    chk("hold_sync_ignored", instr_cnt, 32'd0);

    // Pass trap.
    cyc(1'b0, 1'b1, 16'h8000);
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'h8002);
    cyc(1'b0, 1'b1, 16'hFFF0);
    chk("pass_not_yet", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 16'hFFF0);
    chk("pass_done", 32'(done),      32'd1);
    chk("pass_pass", 32'(pass),      32'd1);
    chk("pass_fail", 32'(fail),      32'd0);
    chk("pass_trap", 32'(trap_addr), 32'h0000FFF0);
    chk("pass_icnt", instr_cnt,      32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'hFFF0);
    chk("pass_frozen", instr_cnt, 32'd4);

    // Fail trap.
    do_reset();
    cyc(1'b0, 1'b1, 16'h8000);
    cyc(1'b0, 1'b1, 16'h9000);
    cyc(1'b0, 1'b1, 16'h9000);
    chk("ftrap_fail", 32'(fail),      32'd1);
    chk("ftrap_pass", 32'(pass),      32'd0);
    chk("ftrap_to",   32'(timeout),   32'd0);
    chk("ftrap_addr", 32'(trap_addr), 32'h00009000);

    // Watchdog with no repeated fetch.
    do_reset();
    for (int i = 0; i < 60; i++) cyc(1'b0, (i % 3) != 0, 16'h4000 + 16'(i));
    chk("wd_done",  32'(done),    32'd1);
    chk("wd_fail",  32'(fail),    32'd1);
    chk("wd_to",    32'(timeout), 32'd1);
    chk("wd_cycle", cycle_cnt,    32'd49);

    // Trap lands on the watchdog cycle: trap wins.
    do_reset();
    for (int i = 0; i < 47; i++) cyc(1'b0, 1'b1, 16'h5000 + 16'(i));
    cyc(1'b0, 1'b1, 16'h6000);
    chk("wdt_not_yet", 32'(done), 32'd0);
    cyc(1'b0, 1'b1, 16'h6000);
    chk("wdt_to",    32'(timeout),   32'd0);
    chk("wdt_fail",  32'(fail),      32'd1);
    chk("wdt_trap",  32'(trap_addr), 32'h00006000);
    chk("wdt_cycle", cycle_cnt,      32'd49);

    // Mid-run reset at cycle 20.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'h7000 + 16'(i));
    chk("mid_cycle20", cycle_cnt, 32'd20);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("mid_cycle", cycle_cnt,      32'd0);
    chk("mid_icnt",  instr_cnt,      32'd0);
    chk("mid_cpu",   32'(cpu_rst_n), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("mid_hold", 32'(cpu_rst_n), 32'd0);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("mid_run", 32'(cpu_rst_n), 32'd1);

    // Fetch history wrap.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 16'h0100 + 16'(i));
    @(negedge clk);
    sync = 1'b0; hist_idx = 3'd0;
    #1;
`ifdef K6502_RUN_CTL_HIST_EN
    chk("hist0", 32'(hist_addr), 32'h00000109);
`else
    chk("hist0", 32'(hist_addr), 32'h00000000);
`endif
    hist_idx = 3'd7;
    #1;
`ifdef K6502_RUN_CTL_HIST_EN
    chk("hist7", 32'(hist_addr), 32'h00000102);
`else
    chk("hist7", 32'(hist_addr), 32'h00000000);
`endif

    // Randomized runs with a small address pool so traps and timeouts both occur.
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int i = 0; i < 70; i++)
        cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, pool_addr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
